// File: rtl/ncc_peak_finder_if.sv
// Handshake bundle between a row-sum producer and ncc_peak_finder: beat input,
// result output and status.
interface ncc_peak_finder_if #(
  parameter int unsigned POS_X = 40,
  parameter int unsigned POS_Y = 40
);
  localparam int unsigned XW = (POS_X > 1) ? $clog2(POS_X) : 1;
  localparam int unsigned YW = (POS_Y > 1) ? $clog2(POS_Y) : 1;

  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [15:0][7:0]      in_row_sum;
  logic                  res_valid;
  logic                  res_ready;
  logic signed [11:0]    best_score;
  logic [XW-1:0]         best_x;
  logic [YW-1:0]         best_y;
  logic                  busy;

  modport master (
    output start, in_valid, in_row_sum, res_ready,
    input  in_ready, res_valid, best_score, best_x, best_y, busy
  );

  modport slave (
    input  start, in_valid, in_row_sum, res_ready,
    output in_ready, res_valid, best_score, best_x, best_y, busy
  );
endinterface

// File: rtl/ncc_peak_finder.sv
// Peak finder over a raster of NCC window scores; each beat's score is the sum of 16 row sums.
// Define NCC_PEAK_PIPE_EN to register the adder tree (compare one cycle after acceptance).
module ncc_peak_finder #(
  parameter int unsigned POS_X = 40,
  parameter int unsigned POS_Y = 40
) (
  input logic               clk,
  input logic               rst,
  ncc_peak_finder_if.slave  bus
);
  localparam int unsigned XW     = (POS_X > 1) ? $clog2(POS_X) : 1;
  localparam int unsigned YW     = (POS_Y > 1) ? $clog2(POS_Y) : 1;
  localparam int unsigned NBeats = POS_X * POS_Y;
  localparam int unsigned CW     = $clog2(NBeats + 1);

`ifdef NCC_PEAK_PIPE_EN
  localparam logic DrainLast = 1'b1;
`else
  localparam logic DrainLast = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               have_q, have_d;
  logic               drain_cnt_q, drain_cnt_d;
  logic signed [11:0] best_score_q, best_score_d;
  logic [XW-1:0]      best_x_q, best_x_d;
  logic [YW-1:0]      best_y_q, best_y_d;

  logic               accept;
  logic signed [11:0] score;
  logic               cmp_vld;
  logic signed [11:0] cmp_score;
  logic [XW-1:0]      cmp_x;
  logic [YW-1:0]      cmp_y;

  assign accept = bus.in_valid && (state_q == StScan);

  // 16 x 8-bit signed terms fit in 12 bits without overflow.
  always_comb begin
    score = '0;
    for (int i = 0; i < 16; i++) begin
      score = score + $signed({{4{bus.in_row_sum[i][7]}}, bus.in_row_sum[i]});
    end
  end

`ifdef NCC_PEAK_PIPE_EN
  logic               pipe_vld_q;
  logic signed [11:0] pipe_score_q;
  logic [XW-1:0]      pipe_x_q;
  logic [YW-1:0]      pipe_y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q   <= 1'b0;
      pipe_score_q <= '0;
      pipe_x_q     <= '0;
      pipe_y_q     <= '0;
    end else begin
      pipe_vld_q   <= accept;
      pipe_score_q <= score;
      pipe_x_q     <= x_q;
      pipe_y_q     <= y_q;
    end
  end

  assign cmp_vld   = pipe_vld_q;
  assign cmp_score = pipe_score_q;
  assign cmp_x     = pipe_x_q;
  assign cmp_y     = pipe_y_q;
`else
  assign cmp_vld   = accept;
  assign cmp_score = score;
  assign cmp_x     = x_q;
  assign cmp_y     = y_q;
`endif

  // Best tracking: first compared beat loads unconditionally, later ones need a strict win.
  always_comb begin
    best_score_d = best_score_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    have_d       = have_q;
    if (state_q == StIdle && bus.start) begin
      have_d = 1'b0;
    end else if (cmp_vld && (!have_q || cmp_score > best_score_q)) begin
      best_score_d = cmp_score;
      best_x_d     = cmp_x;
      best_y_d     = cmp_y;
      have_d       = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StScan;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
        end
      end
      StScan: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (x_q == XW'(POS_X - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(POS_Y - 1)) ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (cnt_q == CW'(NBeats - 1)) begin
            state_d     = StDrain;
            drain_cnt_d = 1'b0;
          end
        end
      end
      StDrain: begin
        if (drain_cnt_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      StDone: begin
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      have_q       <= 1'b0;
      drain_cnt_q  <= 1'b0;
      best_score_q <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      have_q       <= have_d;
      drain_cnt_q  <= drain_cnt_d;
      best_score_q <= best_score_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
    end
  end

  assign bus.in_ready   = (state_q == StScan);
  assign bus.res_valid  = (state_q == StDone);
  assign bus.busy       = (state_q != StIdle);
  assign bus.best_score = best_score_q;
  assign bus.best_x     = best_x_q;
  assign bus.best_y     = best_y_q;
endmodule

// File: tb/tb_ncc_peak_finder.sv
// Self-checking bench for ncc_peak_finder (POS_X=4, POS_Y=2) against a raster-order
// first-maximum reference; expected result latency follows NCC_PEAK_PIPE_EN.
module tb_ncc_peak_finder;
  localparam int PX = 4;
  localparam int PY = 2;
  localparam int NB = PX * PY;
`ifdef NCC_PEAK_PIPE_EN
  localparam int ExpLat = 3;
`else
  localparam int ExpLat = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   beats [NB][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  ncc_peak_finder_if #(.POS_X(PX), .POS_Y(PY)) bif ();

  ncc_peak_finder #(.POS_X(PX), .POS_Y(PY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  // Reference: the earliest raster position holding the largest sum of 16 row values.
  task automatic ref_best(output int s, output int x, output int y);
    int sum;
    s = 0; x = 0; y = 0;
    for (int b = 0; b < NB; b++) begin
      sum = 0;
      for (int r = 0; r < 16; r++) sum += beats[b][r];
      if (b == 0 || sum > s) begin
        s = sum;
        x = b % PX;
        y = b / PX;
      end
    end
  endtask

  task automatic fill_all(input int v);
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < 16; r++) beats[b][r] = v;
  endtask

  task automatic fill_beat(input int b, input int v);
    for (int r = 0; r < 16; r++) beats[b][r] = v;
  endtask

  task automatic drive_beat(input int b);
    int v;
    for (int r = 0; r < 16; r++) begin
      v = beats[b][r];
      bif.in_row_sum[r] = v[7:0];
    end
  endtask

  task automatic check_best(input string name, input int es, input int ex, input int ey);
    logic signed [11:0] s12;
    logic [1:0]         xv;
    logic [0:0]         yv;
    s12 = es[11:0];
    xv  = ex[1:0];
    yv  = ey[0:0];
    checks++;
    if (bif.best_score !== s12 || bif.best_x !== xv || bif.best_y !== yv) begin
      failures++;
      $display("FAIL %s best: got score=%0d x=%0d y=%0d, want score=%0d x=%0d y=%0d", name,
               bif.best_score, bif.best_x, bif.best_y, es, ex, ey);
    end
  endtask

  task automatic run_frame(input string name, input bit gaps, input int hold,
                           input int es, input int ex, input int ey);
    int last_c;
    int guard;
    @(negedge clk);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (gaps) begin
        bif.in_valid = 1'b0;
        bif.start    = 1'b1;  // must be ignored outside IDLE
        @(negedge clk);
        bif.start    = 1'b0;
      end
      drive_beat(b);
      bif.in_valid = 1'b1;
      checks++;
      if (bif.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s in_ready beat %0d: got %b want 1", name, b, bif.in_ready);
      end
      last_c = cyc;
      @(negedge clk);
    end
    // Keep offering a winning beat; it must not transfer outside SCAN.
    bif.in_valid = 1'b1;
    for (int r = 0; r < 16; r++) bif.in_row_sum[r] = 8'd127;
    guard = 0;
    while (bif.res_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bif.res_valid !== 1'b1 || cyc - last_c != ExpLat) begin
      failures++;
      $display("FAIL %s latency: got res_valid=%b after %0d cycles, want 1 after %0d", name,
               bif.res_valid, cyc - last_c, ExpLat);
    end
    checks++;
    if (bif.in_ready !== 1'b0 || bif.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s done flags: got in_ready=%b busy=%b, want 0 1", name, bif.in_ready,
               bif.busy);
    end
    check_best(name, es, ex, ey);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (bif.res_valid !== 1'b1 || bif.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s hold %0d: got res_valid=%b in_ready=%b, want 1 0", name, h,
                 bif.res_valid, bif.in_ready);
      end
      check_best({name, "_hold"}, es, ex, ey);
    end
    bif.res_ready = 1'b1;
    @(negedge clk);
    bif.res_ready = 1'b0;
    bif.in_valid  = 1'b0;
    checks++;
    if (bif.res_valid !== 1'b0 || bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s release: got res_valid=%b busy=%b, want 0 0", name, bif.res_valid,
               bif.busy);
    end
    check_best({name, "_idle"}, es, ex, ey);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (bif.in_ready !== 1'b0 || bif.res_valid !== 1'b0 || bif.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset flags: got in_ready=%b res_valid=%b busy=%b, want 0 0 0",
               bif.in_ready, bif.res_valid, bif.busy);
    end
    check_best("reset", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_peak;
    fill_all(1);
    fill_beat(5, 3);
    run_frame("peak", 1'b0, 1, 48, 1, 1);
  endtask

  task automatic test_all_min;
    fill_all(-128);
    run_frame("all_min", 1'b0, 0, -2048, 0, 0);
  endtask

  task automatic test_tie;
    fill_all(1);
    fill_beat(2, 127);
    fill_beat(6, 127);
    run_frame("tie", 1'b0, 0, 2032, 2, 0);
  endtask

  task automatic test_gaps;
    fill_all(1);
    fill_beat(5, 3);
    run_frame("gaps", 1'b1, 5, 48, 1, 1);
  endtask

  task automatic test_abort;
    int es, ex, ey;
    fill_all(100);
    @(negedge clk);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      drive_beat(b);
      bif.in_valid = 1'b1;
      @(negedge clk);
    end
    bif.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bif.res_valid !== 1'b0 || bif.busy !== 1'b0 || bif.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort flags: got res_valid=%b busy=%b in_ready=%b, want 0 0 0",
               bif.res_valid, bif.busy, bif.in_ready);
    end
    check_best("abort", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bif.res_valid !== 1'b0 || bif.busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle: got res_valid=%b busy=%b, want 0 0", bif.res_valid,
                 bif.busy);
      end
    end
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < 16; r++) beats[b][r] = int'($urandom_range(18)) - 9;
    fill_beat(0, 10);
    ref_best(es, ex, ey);
    run_frame("restart", 1'b0, 0, es, ex, ey);
  endtask

  task automatic test_random;
    int es, ex, ey;
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < NB; b++)
        for (int r = 0; r < 16; r++) beats[b][r] = int'($urandom_range(255)) - 128;
      if (f == 5) beats[7] = beats[3];  // equal-score pair to exercise tie handling
      ref_best(es, ex, ey);
      run_frame("random", 1'($urandom_range(1)), int'($urandom_range(3)), es, ex, ey);
    end
  endtask

  initial begin
    bif.start      = 1'b0;
    bif.in_valid   = 1'b0;
    bif.res_ready  = 1'b0;
    bif.in_row_sum = '0;
    test_reset();
    test_peak();
    test_all_min();
    test_tie();
    test_gaps();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ncc_peak_finder.md
NCC_PEAK_FINDER -- requirements
Module: ncc_peak_finder

Interface
REQ-001 SHALL have parameter POS_X, default 40: window positions per search row.
REQ-002 SHALL have parameter POS_Y, default 40: search rows per frame.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle pulse that begins a search frame; honoured only in IDLE.
REQ-006 in_valid  input  1  in_row_sum holds one window position's 16 row partial sums.
REQ-007 in_row_sum  input  16x8  signed two's-complement accumulator outputs of the 16 PE rows, index 0..15.
REQ-008 in_ready  output  1  asserted in SCAN only; a beat transfers when in_valid && in_ready.
REQ-009 res_valid  output  1  result available; held until accepted.
REQ-010 res_ready  input  1  consumer accepts the result when res_valid && res_ready.
REQ-011 best_score  output  12  signed peak score of the frame.
REQ-012 best_x  output  $clog2(POS_X)  column index of the peak.
REQ-013 best_y  output  $clog2(POS_Y)  row index of the peak.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Score SHALL be the sign-extended 12-bit sum of all 16 in_row_sum entries; range -2048..2032, no overflow possible.
REQ-016 States SHALL be IDLE, SCAN, DRAIN, DONE.
REQ-017 IDLE->SCAN on start; clears x/y position counters, beat counter and first-beat flag.
REQ-018 In SCAN each accepted beat SHALL be assigned position (x,y) in raster order: x increments 0..POS_X-1, then wraps to 0 with y incrementing.
REQ-019 First scored beat of a frame SHALL load best_score/best_x/best_y unconditionally.
REQ-020 Later beats SHALL replace the best only if score > best_score (strict, signed); ties keep the earliest raster position.
REQ-021 After beat number POS_X*POS_Y is accepted, in_ready SHALL drop the next cycle and FSM SHALL go SCAN->DRAIN.
REQ-022 DRAIN SHALL last until the final beat's compare has updated the best registers, then go to DONE.
REQ-023 DONE SHALL hold res_valid=1 and stable best_* until res_valid && res_ready, then return to IDLE with res_valid=0 the next cycle.
REQ-024 start outside IDLE SHALL be ignored; in_valid outside SCAN SHALL be ignored (no transfer, in_ready=0).
REQ-025 in_valid gaps in SCAN SHALL stall counters and leave best registers unchanged.
REQ-026 best_* SHALL be held between frames and change only through REQ-019/REQ-020.

Reset
REQ-027 rst SHALL asynchronously force IDLE and set in_ready=0, res_valid=0, busy=0, best_score=0, best_x=0, best_y=0, all counters and pipeline valids to 0.
REQ-028 rst asserted mid-SCAN or mid-DONE SHALL discard the partial frame; no result is produced.

Configuration
REQ-029 Macro NCC_PEAK_PIPE_EN SHALL select pipelining of the adder tree.
REQ-030 With NCC_PEAK_PIPE_EN defined: the 16-input sum is registered with its valid and position; compare/update occurs one cycle after acceptance; DRAIN lasts 2 cycles.
REQ-031 Without NCC_PEAK_PIPE_EN: sum and compare are combinational in the accept cycle; best_* update at that cycle's edge; DRAIN lasts 1 cycle.
REQ-032 Both builds SHALL produce identical best_* values for identical input streams.

Verification
REQ-033 POS_X=4,POS_Y=2; start; 8 beats with all rows = 1 except beat 5 all rows = 3 -> res_valid, best_score=48, best_x=1, best_y=1.
REQ-034 All 8 beats with every row = -128 -> best_score=-2048, best_x=0, best_y=0 (first beat wins the ties).
REQ-035 Beat 2 rows = 127 and beat 6 rows = 127 -> best_score=2032, best_x=2, best_y=0 (strict > keeps earlier).
REQ-036 in_valid toggling 1/0 every cycle; res_ready low for 5 cycles after res_valid -> same result as contiguous stream; best_* stable throughout the 5 cycles; in_ready=0 in DONE.
REQ-037 rst pulse after beat 3 of a frame, then start with a new frame whose peak is beat 0 = 10 per row -> best_score=160, best_x=0, best_y=0; no res_valid from the aborted frame.
REQ-038 Run REQ-033..REQ-037 with and without NCC_PEAK_PIPE_EN -> identical results; res_valid is 1 cycle later in the pipelined build.
